mips_fetch_unit: RTL

- Parametrised instruction-fetch stage for the MIPS datapath.
- Holds the PC and issues word fetches over a request/acknowledge memory interface, so variable-latency instruction memory is supported.
- Decodes j/jal locally and takes branch/jr redirects from later stages.
- Delivers instructions to decode over a valid/ready handshake, and halts on an all-zero instruction.

---
 rtl/mips_fetch_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack memory
// port, resolves j/jal locally and hands instructions to decode via valid/ready.
module mips_fetch_unit #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00400000,
    parameter int          COUNT_W      = 16,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              halted,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_VECTOR) & WORD_MASK;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic                req_reg;
    logic                squash_reg;
    logic [ADDR_W-1:0]   saved_target_reg;
    logic                inst_valid_reg;
    logic [31:0]         inst_reg;
    logic [ADDR_W-1:0]   inst_pc_reg;
    logic [ADDR_W-1:0]   pc_plus4_reg;
    logic                halted_reg;
    logic [COUNT_W-1:0]  fetch_count_reg;

    logic [ADDR_W-1:0]   seq_pc;
    logic [ADDR_W-1:0]   jump_target;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                is_jump;
    logic                is_halt;

    assign seq_pc      = pc_reg + ADDR_W'(4);
    assign redirect_pc = redirect_target & WORD_MASK;
    // opcodes 6'h02 (j) and 6'h03 (jal) differ only in bit 26
    assign is_jump     = (imem_rdata[31:27] == 5'b00001);
    assign is_halt     = HALT_ON_ZERO && (imem_rdata == 32'h0000_0000);

    // The pseudo-direct jump keeps the region bits above the 28-bit jump field.
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign jump_target = {seq_pc[ADDR_W-1:28], imem_rdata[25:0], 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {imem_rdata[25:0], 2'b00};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= FETCH;
            pc_reg           <= RESET_PC;
            req_reg          <= 1'b0;
            squash_reg       <= 1'b0;
            saved_target_reg <= '0;
            inst_valid_reg   <= 1'b0;
            inst_reg         <= '0;
            inst_pc_reg      <= '0;
            pc_plus4_reg     <= '0;
            halted_reg       <= 1'b0;
            fetch_count_reg  <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (!req_reg) begin
                        // Idle cycle right after reset: nothing outstanding yet.
                        req_reg <= 1'b1;
                        if (redirect_valid) begin
                            pc_reg <= redirect_pc;
                        end
                    end else if (imem_ack) begin
                        if (squash_reg || redirect_valid) begin
                            // Returned word belongs to a dead path; refetch at target.
                            pc_reg     <= redirect_valid ? redirect_pc : saved_target_reg;
                            squash_reg <= 1'b0;
                        end else if (is_halt) begin
                            state_reg  <= HALTED;
                            halted_reg <= 1'b1;
                            req_reg    <= 1'b0;
                        end else begin
                            inst_reg       <= imem_rdata;
                            inst_pc_reg    <= pc_reg;
                            pc_plus4_reg   <= seq_pc;
                            inst_valid_reg <= 1'b1;
                            req_reg        <= 1'b0;
                            state_reg      <= DELIVER;
                            pc_reg         <= is_jump ? jump_target : seq_pc;
                        end
                    end else if (redirect_valid) begin
                        squash_reg       <= 1'b1;
                        saved_target_reg <= redirect_pc;
                    end
                end

                DELIVER: begin
                    if (redirect_valid) begin
                        inst_valid_reg <= 1'b0;
                        pc_reg         <= redirect_pc;
                        req_reg        <= 1'b1;
                        state_reg      <= FETCH;
                    end else if (inst_ready) begin
                        inst_valid_reg  <= 1'b0;
                        fetch_count_reg <= fetch_count_reg + COUNT_W'(1);
                        req_reg         <= 1'b1;
                        state_reg       <= FETCH;
                    end
                end

                HALTED: begin
                    req_reg        <= 1'b0;
                    inst_valid_reg <= 1'b0;
                    halted_reg     <= 1'b1;
                end

                default: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign inst_valid  = inst_valid_reg;
    assign inst        = inst_reg;
    assign inst_pc     = inst_pc_reg;
    assign pc_plus4    = pc_plus4_reg;
    assign halted      = halted_reg;
    assign fetch_count = fetch_count_reg;

endmodule
